special_unit_ctrl: RTL

Iterative multiply/divide sequencer for the special (HI/LO) instructions flagged by the decoder's `Special_En`. It accepts one mult/multu/div/divu operation at a time and runs a 1-bit-per-cycle shift-add multiplier or restoring divider. It holds results in HI/LO and stalls the pipeline while busy. It sits beside the ALU in the execute stage.

---
 rtl/special_unit_ctrl_if.sv | 25 ++
 rtl/special_unit_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/special_unit_ctrl_if.sv
// rtl/special_unit_ctrl_if.sv - launch/result signal bundle between decoder/pipeline and the HI/LO mul/div unit
interface special_unit_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       sel;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             stall;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             dz;

    modport master (
        output start, sel, a, b,
        input  stall, busy, done, hi, lo, dz
    );

    modport slave (
        input  start, sel, a, b,
        output stall, busy, done, hi, lo, dz
    );
endinterface

// File: rtl/special_unit_ctrl.sv
// rtl/special_unit_ctrl.sv - iterative mult/multu/div/divu sequencer with HI/LO; SPECIAL_EARLY_OUT_EN enables multiply early exit
module special_unit_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    special_unit_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_PREP, S_CALC, S_FIX} state_t;

    state_t             r_state;
    state_t             w_next;

    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [1:0]         r_sel;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_ql;
    logic [WIDTH-1:0]   r_opb;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_dz;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_signed;
    logic               w_is_div;
    logic               w_div_zero;
    logic               w_done;
    logic               w_early;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_diff;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_sh;
    logic [2*WIDTH-1:0] w_prod_fx;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_fix_hi;
    logic [WIDTH-1:0]   w_fix_lo;

    assign w_signed   = ~r_sel[0];
    assign w_is_div   = r_sel[1];
    assign w_div_zero = w_is_div && (r_b == '0);
    assign w_abs_a    = (w_signed && r_a[WIDTH-1]) ? -r_a : r_a;
    assign w_abs_b    = (w_signed && r_b[WIDTH-1]) ? -r_b : r_b;

    // Multiply step: conditional add into the upper half, then shift {acc, mplier} right.
    assign w_sum   = {1'b0, r_acc} + (r_ql[0] ? {1'b0, r_opb} : '0);
    // Divide step: shift {rem, quot} left, trial-subtract; the borrow bit decides commit.
    assign w_shift = {r_acc, r_ql[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, r_opb};

    assign w_prod  = {r_acc, r_ql};

`ifdef SPECIAL_EARLY_OUT_EN
    logic [WIDTH-1:0] w_rem_mask;
    // Low r_cnt bits of the multiplier register are the bits not yet consumed.
    assign w_rem_mask = ~({WIDTH{1'b1}} << r_cnt);
    assign w_early    = ~w_is_div && ((r_ql & w_rem_mask) == '0);
    assign w_prod_sh  = w_prod >> r_cnt;
`else
    assign w_early    = 1'b0;
    assign w_prod_sh  = w_prod;
`endif

    assign w_prod_fx = r_neg_q ? -w_prod_sh : w_prod_sh;
    assign w_quot    = r_neg_q ? -r_ql : r_ql;
    assign w_rem     = r_neg_r ? -r_acc : r_acc;

    always_comb begin
        w_fix_hi = w_prod_fx[2*WIDTH-1:WIDTH];
        w_fix_lo = w_prod_fx[WIDTH-1:0];
        if (r_dz) begin
            w_fix_hi = r_a;
            w_fix_lo = '1;
        end else if (w_is_div) begin
            w_fix_hi = w_rem;
            w_fix_lo = w_quot;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (bus.start) w_next = S_PREP;
            S_PREP: w_next = w_div_zero ? S_FIX : S_CALC;
            S_CALC: begin
                if (w_early || (r_cnt == CNT_W'(1))) begin
                    w_next = S_FIX;
                end
            end
            S_FIX:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sel   <= '0;
            r_acc   <= '0;
            r_ql    <= '0;
            r_opb   <= '0;
            r_cnt   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_dz    <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_a   <= bus.a;
                        r_b   <= bus.b;
                        r_sel <= bus.sel;
                        r_dz  <= 1'b0;
                    end
                end
                S_PREP: begin
                    r_neg_q <= w_signed && (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
                    r_neg_r <= w_signed && r_a[WIDTH-1];
                    r_acc   <= '0;
                    r_cnt   <= CNT_W'(WIDTH);
                    if (w_is_div) begin
                        r_ql  <= w_abs_a;
                        r_opb <= w_abs_b;
                    end else begin
                        r_ql  <= w_abs_b;
                        r_opb <= w_abs_a;
                    end
                    if (w_div_zero) r_dz <= 1'b1;
                end
                S_CALC: begin
                    if (!w_early) begin
                        r_cnt <= r_cnt - 1'b1;
                        if (w_is_div) begin
                            r_acc <= w_diff[WIDTH] ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
                            r_ql  <= {r_ql[WIDTH-2:0], ~w_diff[WIDTH]};
                        end else begin
                            r_acc <= w_sum[WIDTH:1];
                            r_ql  <= {w_sum[0], r_ql[WIDTH-1:1]};
                        end
                    end
                end
                S_FIX: begin
                    r_hi <= w_fix_hi;
                    r_lo <= w_fix_lo;
                end
                default: ;
            endcase
        end
    end

    // HI/LO show the fixed-up result combinationally so it is valid in the done cycle.
    assign w_done    = (r_state == S_FIX);
    assign bus.done  = w_done;
    assign bus.busy  = (r_state != S_IDLE);
    assign bus.stall = ((r_state == S_IDLE) && bus.start) || ((r_state != S_IDLE) && !w_done);
    assign bus.hi    = w_done ? w_fix_hi : r_hi;
    assign bus.lo    = w_done ? w_fix_lo : r_lo;
    assign bus.dz    = r_dz;
endmodule
